// File: rtl/lr3_ce_pkg.sv
// lr3_ce_pkg: shared default constants and divisor word type for the multi-channel CE generator
package lr3_ce_pkg;
   localparam int DIV_W_C = 16;
   localparam int DEF_DIV_C = 50;
   localparam int N_DIGITS_C = 8;
   localparam int N_CH_C = 4;
   localparam int CH_W_C = (N_CH_C > 1) ? $clog2(N_CH_C) : 1;
   typedef logic [DIV_W_C-1:0] div_word_t;
endpackage

// File: rtl/lr3_ce_div_ch.sv
// lr3_ce_div_ch: one CE channel with shadowed divisor applied only at a wrap or a sync
module lr3_ce_div_ch import lr3_ce_pkg::*; #(
   parameter int DIV_W = DIV_W_C,
   parameter int DEF_DIV = DEF_DIV_C
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             sync,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_data,
   output logic             ce,
   output logic             pend
);
   logic [DIV_W-1:0] cnt, div_act, div_shd, last;
   logic wrap, apply;
   always_comb begin
      last = (div_act <= DIV_W'(1)) ? '0 : div_act - DIV_W'(1);
      wrap = run && cnt == last;
      apply = sync || wrap;
   end
   always_ff @(posedge CLK)
      if (RST) begin
         cnt <= '0;
         div_act <= DIV_W'(DEF_DIV);
         div_shd <= DIV_W'(DEF_DIV);
         pend <= 1'b0;
         ce <= 1'b0;
      end else begin
         cnt <= (sync || !run || wrap) ? '0 : cnt + DIV_W'(1);
         ce <= wrap && !sync;
         if (apply && pend) div_act <= div_shd;
         if (wr) div_shd <= wr_data;
         pend <= wr || (pend && !apply);
      end
endmodule

// File: rtl/lr3_ce_gen_multi.sv
// lr3_ce_gen_multi: N_CH programmable CE strobes; define CE_GEN_DIGIT_SCAN_EN to add the DIGIT_IDX scan counter
module lr3_ce_gen_multi import lr3_ce_pkg::*; #(
   parameter int N_CH = N_CH_C,
   parameter int DIV_W = DIV_W_C,
   parameter int DEF_DIV = DEF_DIV_C,
   parameter int CH_W = CH_W_C
`ifdef CE_GEN_DIGIT_SCAN_EN
   ,
   parameter int N_DIGITS = N_DIGITS_C
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_CH-1:0]  RUN,
   input  logic             SYNC,
   input  logic             WR_EN,
   input  logic [CH_W-1:0]  WR_CH,
   input  logic [DIV_W-1:0] WR_DATA,
   output logic [N_CH-1:0]  CE,
   output logic [N_CH-1:0]  DIV_PEND
`ifdef CE_GEN_DIGIT_SCAN_EN
   ,
   output logic [$clog2(N_DIGITS)-1:0] DIGIT_IDX
`endif
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      lr3_ce_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
         .CLK(CLK),
         .RST(RST),
         .run(RUN[i]),
         .sync(SYNC),
         .wr(WR_EN && WR_CH == CH_W'(i)),
         .wr_data(WR_DATA),
         .ce(CE[i]),
         .pend(DIV_PEND[i])
      );
   end
`ifdef CE_GEN_DIGIT_SCAN_EN
   localparam int IW = $clog2(N_DIGITS);
   always_ff @(posedge CLK)
      if (RST || SYNC) DIGIT_IDX <= '0;
      else if (CE[0]) DIGIT_IDX <= (DIGIT_IDX == IW'(N_DIGITS - 1)) ? '0 : DIGIT_IDX + IW'(1);
`endif
endmodule
